// File: rtl/ac97_reg_arbiter.sv
// Round-robin share of the AC97 shadow-register bus port; one bus access (plus optional 0x68 flush poll) per grant.
// Latency: request to strobe 1 cycle, ack to done_o 1 cycle; requesters hold req_i until done_o, bus stalls on ack_i (bounded by ACK_MAX).
module ac97_reg_arbiter #(
   parameter int          NREQ     = 4,
   parameter logic [63:0] BASE     = 64'hFFFF_FFFF_FFDC_1000,
   parameter int          ACK_MAX  = 15,
   parameter int          POLL_MAX = 1023
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic [NREQ-1:0]    req_i,
   input  logic [NREQ-1:0]    we_i,
   input  logic [NREQ-1:0]    sync_i,
   input  logic [7*NREQ-1:0]  reg_i,
   input  logic [16*NREQ-1:0] wdat_i,
   output logic [NREQ-1:0]    done_o,
   output logic [15:0]        rdat_o,
   output logic               err_o,
   output logic               cyc_o,
   output logic               stb_o,
   output logic               we_o,
   output logic [63:0]        adr_o,
   output logic [15:0]        dat_o,
   input  logic               ack_i,
   input  logic [15:0]        dat_i
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int AW = $clog2(ACK_MAX + 1);
   localparam int PW = $clog2(POLL_MAX + 1);

   typedef enum logic [2:0] {IDLE, BUS, GAP, POLL, DONE} state_t;

   state_t          state_q, state_n;
   logic [IW-1:0]   ptr_q, grant_q;
   logic            cmd_we_q, cmd_sync_q;
   logic [AW-1:0]   wait_q, wait_n;
   logic [PW-1:0]   poll_q, poll_n;
   logic            abort_q, abort_n;
   logic [15:0]     rdat_q, rdat_n;
   logic            cyc_q, we_q, err_q;
   logic [63:0]     adr_q;
   logic [15:0]     dat_q;
   logic [NREQ-1:0] done_q;

   logic            found;
   logic [IW-1:0]   win;
   logic            win_we, win_sync;
   logic [6:0]      win_reg;
   logic [15:0]     win_wdat;
   logic            strobe_n;

   // Two passes: first the indices at or above ptr, then wrap to the low ones.
   always_comb begin
      found    = 1'b0;
      win      = '0;
      win_we   = 1'b0;
      win_sync = 1'b0;
      win_reg  = '0;
      win_wdat = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (!found && req_i[k] && (IW'(k) >= ptr_q)) begin
            found    = 1'b1;
            win      = IW'(k);
            win_we   = we_i[k];
            win_sync = sync_i[k];
            win_reg  = reg_i[7*k +: 7];
            win_wdat = wdat_i[16*k +: 16];
         end
      end
      for (int k = 0; k < NREQ; k++) begin
         if (!found && req_i[k]) begin
            found    = 1'b1;
            win      = IW'(k);
            win_we   = we_i[k];
            win_sync = sync_i[k];
            win_reg  = reg_i[7*k +: 7];
            win_wdat = wdat_i[16*k +: 16];
         end
      end
   end

   always_comb begin
      state_n = state_q;
      wait_n  = wait_q;
      poll_n  = poll_q;
      abort_n = abort_q;
      rdat_n  = rdat_q;
      case (state_q)
         IDLE: if (found) state_n = BUS;
         BUS, POLL: begin
            if (ack_i) begin
               wait_n = '0;
               if (state_q == BUS) begin
                  if (!cmd_we_q) rdat_n = dat_i;
                  state_n = (cmd_we_q && cmd_sync_q) ? GAP : DONE;
               end else begin
                  rdat_n = dat_i;
                  if (dat_i == 16'h0000) begin
                     state_n = DONE;
                  end else if (poll_q == PW'(POLL_MAX - 1)) begin
                     abort_n = 1'b1;
                     state_n = DONE;
                  end else begin
                     poll_n  = poll_q + 1'b1;
                     state_n = GAP;
                  end
               end
            end else if (wait_q == AW'(ACK_MAX - 1)) begin
               wait_n  = '0;
               abort_n = 1'b1;
               state_n = DONE;
            end else begin
               wait_n = wait_q + 1'b1;
            end
         end
         GAP: state_n = POLL;
         DONE: begin
            state_n = IDLE;
            wait_n  = '0;
            poll_n  = '0;
            abort_n = 1'b0;
         end
         default: state_n = IDLE;
      endcase
   end

   assign strobe_n = (state_n == BUS) || (state_n == POLL);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         ptr_q      <= '0;
         grant_q    <= '0;
         cmd_we_q   <= 1'b0;
         cmd_sync_q <= 1'b0;
         wait_q     <= '0;
         poll_q     <= '0;
         abort_q    <= 1'b0;
         rdat_q     <= '0;
         cyc_q      <= 1'b0;
         we_q       <= 1'b0;
         adr_q      <= '0;
         dat_q      <= '0;
         done_q     <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q <= state_n;
         wait_q  <= wait_n;
         poll_q  <= poll_n;
         abort_q <= abort_n;
         rdat_q  <= rdat_n;
         cyc_q   <= strobe_n;
         if (state_q == IDLE && found) begin
            grant_q    <= win;
            cmd_we_q   <= win_we;
            cmd_sync_q <= win_sync;
            adr_q      <= {BASE[63:8], 1'b0, win_reg};
            dat_q      <= win_wdat;
         end else if (state_n == POLL) begin
            adr_q <= {BASE[63:8], 8'h68};
         end
         if (state_n == BUS) we_q <= (state_q == IDLE) ? win_we : cmd_we_q;
         else                we_q <= 1'b0;
         done_q <= (state_n == DONE) ? (NREQ'(1) << grant_q) : '0;
         err_q  <= (state_n == DONE) && abort_n;
         if (state_q == DONE) ptr_q <= (grant_q == IW'(NREQ - 1)) ? '0 : grant_q + 1'b1;
      end
   end

   assign done_o = done_q;
   assign rdat_o = rdat_q;
   assign err_o  = err_q;
   assign cyc_o  = cyc_q;
   assign stb_o  = cyc_q;
   assign we_o   = we_q;
   assign adr_o  = adr_q;
   assign dat_o  = dat_q;

endmodule

// File: tb/tb_ac97_reg_arbiter.sv
// Directed bench for ac97_reg_arbiter: scoreboard of expected completions plus a register-slave model with an access log.
module tb_ac97_reg_arbiter;

   localparam int NREQ = 4;
   localparam logic [63:0] A_POLL = 64'hFFFF_FFFF_FFDC_1068;

   logic              clk_i = 1'b0;
   logic              rst_ni;
   logic [NREQ-1:0]   req_i, we_i, sync_i;
   logic [7*NREQ-1:0] reg_i;
   logic [16*NREQ-1:0] wdat_i;
   logic [NREQ-1:0]   done_o;
   logic [15:0]       rdat_o;
   logic              err_o, cyc_o, stb_o, we_o;
   logic [63:0]       adr_o;
   logic [15:0]       dat_o;
   logic              ack_i;
   logic [15:0]       dat_i;

   always #5 clk_i = ~clk_i;

   ac97_reg_arbiter #(
      .NREQ(NREQ), .BASE(64'hFFFF_FFFF_FFDC_1000), .ACK_MAX(15), .POLL_MAX(4)
   ) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .we_i(we_i), .sync_i(sync_i),
      .reg_i(reg_i), .wdat_i(wdat_i), .done_o(done_o), .rdat_o(rdat_o), .err_o(err_o),
      .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o), .dat_o(dat_o),
      .ack_i(ack_i), .dat_i(dat_i)
   );

   typedef struct {
      int          idx;
      logic [15:0] rdat;
      logic        err;
      logic        chk_rdat;
   } exp_t;

   exp_t        sb[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   int          ack_lat = 1;
   logic [15:0] poll_data[$];
   logic [63:0] acc_adr[$];
   logic        acc_we[$];
   logic [15:0] acc_dat[$];
   int          acc_len[$];
   int          acc_gap[$];

   function automatic logic [15:0] slave_rd(input logic [6:0] r);
      if (r == 7'h7C) return 16'h4E53;
      return {8'hC0, 1'b0, r};
   endfunction

   // Register slave: acks in the ack_lat-th strobe cycle (0 = never); 0x68 reads drain poll_data, then read FFFF.
   initial begin
      int scnt;
      int low;
      ack_i = 1'b0;
      dat_i = '0;
      scnt  = 0;
      low   = 0;
      forever begin
         @(negedge clk_i);
         if (cyc_o && stb_o) begin
            if (scnt == 0) begin
               acc_adr.push_back(adr_o);
               acc_we.push_back(we_o);
               acc_dat.push_back(dat_o);
               acc_len.push_back(0);
               acc_gap.push_back(low);
            end
            acc_len[acc_len.size()-1] = acc_len[acc_len.size()-1] + 1;
            scnt = scnt + 1;
            low  = 0;
            if (ack_lat != 0 && scnt == ack_lat) begin
               ack_i = 1'b1;
               if (adr_o[7:0] == 8'h68)
                  dat_i = (poll_data.size() > 0) ? poll_data.pop_front() : 16'hFFFF;
               else
                  dat_i = slave_rd(adr_o[6:0]);
            end else begin
               ack_i = 1'b0;
            end
         end else begin
            ack_i = 1'b0;
            scnt  = 0;
            low   = low + 1;
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic clear_log();
      acc_adr.delete();
      acc_we.delete();
      acc_dat.delete();
      acc_len.delete();
      acc_gap.delete();
   endtask

   task automatic drive_req(input int k, input logic we, input logic sy,
                            input logic [6:0] r, input logic [15:0] d);
      req_i[k]          = 1'b1;
      we_i[k]           = we;
      sync_i[k]         = sy;
      reg_i[7*k +: 7]   = r;
      wdat_i[16*k +: 16] = d;
   endtask

   task automatic push_exp(input int idx, input logic [15:0] rd, input logic err, input logic cr);
      exp_t e;
      e.idx = idx; e.rdat = rd; e.err = err; e.chk_rdat = cr;
      sb.push_back(e);
   endtask

   task automatic wait_done(input string tag, input logic drop, output int waited);
      int   n;
      logic got;
      exp_t e;
      n   = 0;
      got = 1'b0;
      while (!got && n < 200) begin
         @(negedge clk_i);
         n++;
         if (done_o != '0) got = 1'b1;
      end
      waited = n;
      if (!got) begin
         chk({tag, "_timeout"}, {63'd0, got}, 64'd1);
         if (sb.size() > 0) e = sb.pop_front();
      end else if (sb.size() == 0) begin
         chk({tag, "_unexpected_done"}, {60'd0, done_o}, 64'd0);
      end else begin
         e = sb.pop_front();
         chk({tag, "_done"}, {60'd0, done_o}, 64'd1 << e.idx);
         chk({tag, "_err"}, {63'd0, err_o}, {63'd0, e.err});
         if (e.chk_rdat) chk({tag, "_rdat"}, {48'd0, rdat_o}, {48'd0, e.rdat});
         if (drop) req_i[e.idx] = 1'b0;
      end
   endtask

   task automatic do_reset();
      req_i  = '0;
      rst_ni = 1'b0;
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(negedge clk_i);
   endtask

   initial begin
      int w;
      rst_ni = 1'b0;
      req_i  = '0;
      we_i   = '0;
      sync_i = '0;
      reg_i  = '0;
      wdat_i = '0;
      @(negedge clk_i);
      chk("rst_cyc", {63'd0, cyc_o}, 64'd0);
      chk("rst_stb", {63'd0, stb_o}, 64'd0);
      chk("rst_done", {60'd0, done_o}, 64'd0);
      chk("rst_err", {63'd0, err_o}, 64'd0);
      chk("rst_adr", adr_o, 64'd0);
      chk("rst_rdat", {48'd0, rdat_o}, 64'd0);
      rst_ni = 1'b1;
      @(negedge clk_i);

      // Single read of 0x7C, slave acks in the second strobe cycle.
      clear_log();
      ack_lat = 2;
      drive_req(0, 1'b0, 1'b0, 7'h7C, 16'h0000);
      push_exp(0, 16'h4E53, 1'b0, 1'b1);
      @(negedge clk_i);
      chk("t1_cyc_c1", {63'd0, cyc_o}, 64'd1);
      chk("t1_stb_c1", {63'd0, stb_o}, 64'd1);
      chk("t1_adr", adr_o, 64'hFFFF_FFFF_FFDC_107C);
      chk("t1_we", {63'd0, we_o}, 64'd0);
      @(negedge clk_i);
      chk("t1_cyc_c2", {63'd0, cyc_o}, 64'd1);
      wait_done("t1", 1'b1, w);
      chk("t1_done_cycle", w, 64'd1);
      chk("t1_cyc_off", {63'd0, cyc_o}, 64'd0);

      // All four held: grants 0,1,2,3,0.
      do_reset();
      clear_log();
      ack_lat = 1;
      for (int k = 0; k < NREQ; k++) drive_req(k, 1'b0, 1'b0, 7'(8'h10 + k), 16'h0000);
      for (int r = 0; r < 5; r++) push_exp(r % 4, 16'hC010 + 16'(r % 4), 1'b0, 1'b1);
      for (int r = 0; r < 5; r++) wait_done("t2", 1'b0, w);
      req_i = '0;
      repeat (4) @(negedge clk_i);
      chk("t2_accesses", acc_adr.size(), 64'd5);
      for (int i = 0; i < acc_gap.size(); i++) chk("t2_gap", {63'd0, acc_gap[i] >= 1}, 64'd1);

      // Sync write: 0x68 reads FFFF, FFFF, 0000.
      clear_log();
      poll_data = '{16'hFFFF, 16'hFFFF, 16'h0000};
      drive_req(1, 1'b1, 1'b1, 7'h02, 16'h8000);
      push_exp(1, 16'h0000, 1'b0, 1'b1);
      wait_done("t3", 1'b1, w);
      chk("t3_accesses", acc_adr.size(), 64'd4);
      chk("t3_wr_adr", acc_adr[0], 64'hFFFF_FFFF_FFDC_1002);
      chk("t3_wr_we", {63'd0, acc_we[0]}, 64'd1);
      chk("t3_wr_dat", {48'd0, acc_dat[0]}, 64'h8000);
      for (int i = 1; i < 4 && i < acc_adr.size(); i++) begin
         chk("t3_poll_adr", acc_adr[i], A_POLL);
         chk("t3_poll_we", {63'd0, acc_we[i]}, 64'd0);
         chk("t3_poll_gap", acc_gap[i], 64'd1);
      end

      // Sync write with 0x68 stuck non-zero: POLL_MAX reads, then error.
      repeat (2) @(negedge clk_i);
      clear_log();
      poll_data.delete();
      drive_req(1, 1'b1, 1'b1, 7'h04, 16'h1234);
      push_exp(1, 16'hFFFF, 1'b1, 1'b1);
      wait_done("t4", 1'b1, w);
      chk("t4_accesses", acc_adr.size(), 64'd5);
      for (int i = 1; i < acc_adr.size(); i++) chk("t4_poll_adr", acc_adr[i], A_POLL);

      // No ack: abort after 15 strobe cycles, next requester proceeds.
      do_reset();
      clear_log();
      ack_lat = 0;
      drive_req(2, 1'b0, 1'b0, 7'h20, 16'h0000);
      drive_req(3, 1'b0, 1'b0, 7'h30, 16'h0000);
      push_exp(2, 16'h0000, 1'b1, 1'b0);
      push_exp(3, 16'hC030, 1'b0, 1'b1);
      wait_done("t5a", 1'b1, w);
      chk("t5_done_cycle", w, 64'd16);
      chk("t5_strobe_len", acc_len[0], 64'd15);
      ack_lat = 1;
      wait_done("t5b", 1'b1, w);
      chk("t5b_adr", acc_adr[acc_adr.size()-1], 64'hFFFF_FFFF_FFDC_1030);

      // Reset during a stalled bus cycle, pointer previously at 2.
      clear_log();
      drive_req(1, 1'b0, 1'b0, 7'h11, 16'h0000);
      push_exp(1, 16'hC011, 1'b0, 1'b1);
      wait_done("t6a", 1'b1, w);
      ack_lat = 0;
      drive_req(2, 1'b0, 1'b0, 7'h22, 16'h0000);
      repeat (3) @(negedge clk_i);
      chk("t6_busy", {63'd0, cyc_o}, 64'd1);
      #2 rst_ni = 1'b0;
      #1;
      chk("t6_rst_cyc", {63'd0, cyc_o}, 64'd0);
      chk("t6_rst_stb", {63'd0, stb_o}, 64'd0);
      chk("t6_rst_done", {60'd0, done_o}, 64'd0);
      req_i = '0;
      @(negedge clk_i);
      rst_ni  = 1'b1;
      ack_lat = 1;
      for (int k = 0; k < NREQ; k++) drive_req(k, 1'b0, 1'b0, 7'(8'h40 + k), 16'h0000);
      push_exp(0, 16'hC040, 1'b0, 1'b1);
      wait_done("t6b", 1'b0, w);
      req_i = '0;
      repeat (6) @(negedge clk_i);
      chk("t6_idle_done", {60'd0, done_o}, 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
